// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand stage: register file, operand forwarding, one-slot pipeline register
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready        decode-side handshake
//   in_rs_addr, in_rt_addr   source register addresses
//   in_instr, in_op          ALU function and op fields
//   in_rd_addr, in_wb_en     destination register and write flag
//   flush                    squash slot and current input
//   fwd_valid/addr/data      execute result bypass bus
//   wb_en/addr/data          writeback bus (also writes the register file)
//   out_valid/ex_ready       execute-side handshake
//   out_rs, out_rt           resolved operands
//   out_instr, out_op, out_rd_addr, out_wb_en  registered control fields

module id_ex_operand_stage #(
    parameter int DATA_W = 16,
    parameter int REG_N  = 8,
    localparam int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs_addr,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic [4:0]        in_instr,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              in_wb_en,
    input  logic              flush,
    input  logic              fwd_valid,
    input  logic [ADDR_W-1:0] fwd_addr,
    input  logic [DATA_W-1:0] fwd_data,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              ex_ready,
    output logic [DATA_W-1:0] out_rs,
    output logic [DATA_W-1:0] out_rt,
    output logic [4:0]        out_instr,
    output logic [1:0]        out_op,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic              out_wb_en
);

    logic [DATA_W-1:0] rf_q [REG_N];
    logic [DATA_W-1:0] rf_d [REG_N];

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] rs_q, rs_d;
    logic [DATA_W-1:0] rt_q, rt_d;
    logic [4:0]        instr_q, instr_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              wb_flag_q, wb_flag_d;
    logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;

    logic [DATA_W-1:0] rs_res, rt_res;
    logic              capture, hold;

    // Only ex_ready reaches in_ready combinationally; out_* come straight from flops.
    assign in_ready = ~out_valid_q | ex_ready;
    assign capture  = in_valid & in_ready & ~flush;
    assign hold     = out_valid_q & ~ex_ready;

    always_comb begin
        for (int i = 0; i < REG_N; i++) begin
            rf_d[i] = rf_q[i];
        end
        if (wb_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    // Execute bus is the youngest value, so it overrides writeback, which overrides the array.
    always_comb begin
        rs_res = rf_q[in_rs_addr];
        if (wb_en && (wb_addr == in_rs_addr)) begin
            rs_res = wb_data;
        end
        if (fwd_valid && (fwd_addr == in_rs_addr)) begin
            rs_res = fwd_data;
        end
        rt_res = rf_q[in_rt_addr];
        if (wb_en && (wb_addr == in_rt_addr)) begin
            rt_res = wb_data;
        end
        if (fwd_valid && (fwd_addr == in_rt_addr)) begin
            rt_res = fwd_data;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        instr_d     = instr_q;
        op_d        = op_q;
        rd_addr_d   = rd_addr_q;
        wb_flag_d   = wb_flag_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d = 1'b1;
        end else if (out_valid_q && ex_ready) begin
            out_valid_d = 1'b0;
        end

        if (capture) begin
            rs_d      = rs_res;
            rt_d      = rt_res;
            instr_d   = in_instr;
            op_d      = in_op;
            rd_addr_d = in_rd_addr;
            wb_flag_d = in_wb_en;
            rs_addr_d = in_rs_addr;
            rt_addr_d = in_rt_addr;
        end else if (hold && wb_en) begin
            // A stalled slot must not leave with a stale operand once the producer retires.
            if (wb_addr == rs_addr_q) begin
                rs_d = wb_data;
            end
            if (wb_addr == rt_addr_q) begin
                rt_d = wb_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            rs_q        <= '0;
            rt_q        <= '0;
            instr_q     <= '0;
            op_q        <= '0;
            rd_addr_q   <= '0;
            wb_flag_q   <= 1'b0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
        end else begin
            for (int i = 0; i < REG_N; i++) begin
                rf_q[i] <= rf_d[i];
            end
            out_valid_q <= out_valid_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            instr_q     <= instr_d;
            op_q        <= op_d;
            rd_addr_q   <= rd_addr_d;
            wb_flag_q   <= wb_flag_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_rs      = rs_q;
    assign out_rt      = rt_q;
    assign out_instr   = instr_q;
    assign out_op      = op_q;
    assign out_rd_addr = rd_addr_q;
    assign out_wb_en   = wb_flag_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_rs_addr, in_rt_addr, in_rd_addr;
    logic [4:0]  in_instr;
    logic [1:0]  in_op;
    logic        in_wb_en;
    logic        flush;
    logic        fwd_valid;
    logic [2:0]  fwd_addr;
    logic [15:0] fwd_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        out_valid;
    logic        ex_ready;
    logic [15:0] out_rs, out_rt;
    logic [4:0]  out_instr;
    logic [1:0]  out_op;
    logic [2:0]  out_rd_addr;
    logic        out_wb_en;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr),
        .in_instr(in_instr), .in_op(in_op),
        .in_rd_addr(in_rd_addr), .in_wb_en(in_wb_en),
        .flush(flush),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .ex_ready(ex_ready),
        .out_rs(out_rs), .out_rt(out_rt),
        .out_instr(out_instr), .out_op(out_op),
        .out_rd_addr(out_rd_addr), .out_wb_en(out_wb_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rs;
        logic [15:0] rt;
        logic [4:0]  instr;
        logic [1:0]  op;
        logic [2:0]  rd;
        logic        wbf;
        logic [2:0]  rs_a;
        logic [2:0]  rt_a;
    } slot_t;

    slot_t       exp_q[$];
    logic [15:0] m_mem [8];
    logic        m_valid;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] resolve(input logic [2:0] a);
        if (fwd_valid && fwd_addr == a) return fwd_data;
        if (wb_en && wb_addr == a) return wb_data;
        return m_mem[a];
    endfunction

    // Reference model: advances by one clock edge using the inputs that were
    // applied during the cycle that just ended.
    task automatic apply_edge();
        logic  rdy, cap, hld;
        slot_t s;
        rdy = !m_valid || ex_ready;
        cap = in_valid && rdy && !flush;
        hld = m_valid && !ex_ready;
        if (hld && exp_q.size() > 0) begin
            if (flush) begin
                void'(exp_q.pop_front());
            end else if (wb_en) begin
                if (exp_q[0].rs_a == wb_addr) exp_q[0].rs = wb_data;
                if (exp_q[0].rt_a == wb_addr) exp_q[0].rt = wb_data;
            end
        end
        if (cap) begin
            s.rs = resolve(in_rs_addr);
            s.rt = resolve(in_rt_addr);
            s.instr = in_instr;
            s.op = in_op;
            s.rd = in_rd_addr;
            s.wbf = in_wb_en;
            s.rs_a = in_rs_addr;
            s.rt_a = in_rt_addr;
            exp_q.push_back(s);
        end
        if (flush) m_valid = 1'b0;
        else if (cap) m_valid = 1'b1;
        else if (m_valid && ex_ready) m_valid = 1'b0;
        if (wb_en) m_mem[wb_addr] = wb_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        apply_edge();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_mem[i] = '0;
        exp_q.delete();
        m_valid = 1'b0;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0;
        in_instr = 0; in_op = 0; in_wb_en = 0; flush = 0;
        fwd_valid = 0; fwd_addr = 0; fwd_data = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; ex_ready = 1;
    endtask

    // Monitor: compares the presented slot against the scoreboard head,
    // retiring it when the execute side takes it.
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", {15'd0, in_ready}, {15'd0, (!m_valid || ex_ready)});
            check("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 16'd1, 16'd0);
                end else begin
                    check("out_rs", out_rs, exp_q[0].rs);
                    check("out_rt", out_rt, exp_q[0].rt);
                    check("out_instr", {11'd0, out_instr}, {11'd0, exp_q[0].instr});
                    check("out_op", {14'd0, out_op}, {14'd0, exp_q[0].op});
                    check("out_rd_addr", {13'd0, out_rd_addr}, {13'd0, exp_q[0].rd});
                    check("out_wb_en", {15'd0, out_wb_en}, {15'd0, exp_q[0].wbf});
                    if (ex_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_in_ready", {15'd0, in_ready}, 16'd1);
        check("rst_out_rs", out_rs, 16'd0);
        check("rst_out_rt", out_rt, 16'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Write R3, then read it from the array
        wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
        step();
        wb_en = 0;
        in_valid = 1; in_rs_addr = 3; in_rt_addr = 3; in_instr = 5'h0A; in_op = 2'd1;
        step();
        check("t1_valid", {15'd0, out_valid}, 16'd1);
        check("t1_rs", out_rs, 16'h1234);
        check("t1_rt", out_rt, 16'h1234);
        in_valid = 0;
        step();

        // Same-cycle fwd beats wb; array keeps wb value
        in_valid = 1; in_rs_addr = 5; in_rt_addr = 0;
        wb_en = 1; wb_addr = 5; wb_data = 16'h00FF;
        fwd_valid = 1; fwd_addr = 5; fwd_data = 16'hBEEF;
        step();
        check("t2_fwd_rs", out_rs, 16'hBEEF);
        wb_en = 0; fwd_valid = 0;
        step();
        check("t2_array_rs", out_rs, 16'h00FF);
        in_valid = 0;
        step();

        // Stall-hold with writeback into a held source
        wb_en = 1; wb_addr = 2; wb_data = 16'h0001;
        step();
        wb_en = 0;
        in_valid = 1; in_rs_addr = 2; in_rt_addr = 7; in_instr = 5'h11; in_op = 2'd2;
        step();
        check("t3_rs_init", out_rs, 16'h0001);
        ex_ready = 0; in_instr = 5'h03;
        step();
        check("t3_in_ready_c1", {15'd0, in_ready}, 16'd0);
        wb_en = 1; wb_addr = 2; wb_data = 16'h8000;
        step();
        check("t3_rs_updated", out_rs, 16'h8000);
        check("t3_instr_held", {11'd0, out_instr}, 16'h0011);
        check("t3_in_ready_c2", {15'd0, in_ready}, 16'd0);
        wb_en = 0;
        step();
        check("t3_in_ready_c3", {15'd0, in_ready}, 16'd0);
        in_valid = 0; ex_ready = 1;
        step();
        step();

        // Back-to-back
        for (int i = 0; i < 4; i++) begin
            in_valid = 1; in_instr = 5'(i + 20); in_op = 2'(i);
            in_rs_addr = 3'(i); in_rt_addr = 3'(7 - i);
            step();
            check("t4_valid", {15'd0, out_valid}, 16'd1);
            check("t4_instr", {11'd0, out_instr}, {11'd0, 5'(i + 20)});
            check("t4_in_ready", {15'd0, in_ready}, 16'd1);
        end
        in_valid = 0;
        step();

        // Flush drops input but the register write lands
        in_valid = 1; flush = 1; in_rs_addr = 6;
        wb_en = 1; wb_addr = 6; wb_data = 16'hABCD;
        step();
        check("t5_flush_valid", {15'd0, out_valid}, 16'd0);
        flush = 0; wb_en = 0;
        step();
        check("t5_wb_present", out_rs, 16'hABCD);
        in_valid = 0;
        step();

        // Asynchronous reset mid-stall
        in_valid = 1; in_rs_addr = 3; in_rt_addr = 6; ex_ready = 0;
        step();
        step();
        rst = 0;
        #1;
        check("t6_valid", {15'd0, out_valid}, 16'd0);
        check("t6_rs", out_rs, 16'd0);
        check("t6_rt", out_rt, 16'd0);
        check("t6_instr", {11'd0, out_instr}, 16'd0);
        check("t6_in_ready", {15'd0, in_ready}, 16'd1);
        model_reset();
        in_valid = 0; ex_ready = 1;
        #1;
        rst = 1;
        in_valid = 1; in_rs_addr = 3; in_rt_addr = 6;
        step();
        check("t6_r3_cleared", out_rs, 16'd0);
        check("t6_r6_cleared", out_rt, 16'd0);
        in_valid = 0;
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            in_valid   = ($urandom_range(3) != 0);
            ex_ready   = ($urandom_range(2) != 0);
            flush      = ($urandom_range(15) == 0);
            in_rs_addr = 3'($urandom_range(7));
            in_rt_addr = 3'($urandom_range(7));
            in_rd_addr = 3'($urandom_range(7));
            in_instr   = 5'($urandom_range(31));
            in_op      = 2'($urandom_range(3));
            in_wb_en   = 1'($urandom_range(1));
            fwd_valid  = 1'($urandom_range(1));
            fwd_addr   = 3'($urandom_range(7));
            fwd_data   = 16'($urandom);
            wb_en      = 1'($urandom_range(1));
            wb_addr    = 3'($urandom_range(7));
            wb_data    = 16'($urandom);
            step();
        end
        idle_inputs();
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
